// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package arm_fetch_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    EXEC  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  // Instructions are word aligned; only the two low PC bits matter.
  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return pc_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Architectural PC register: loads on enable, resets asynchronously to RESET_PC.
module pc_register
  import arm_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] d_i,
  output logic [ADDR_W-1:0] q_o
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else if (en_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: requests the word at CurrentPC, hands it to decode, then waits for the PC commit.
// Optional misaligned-PC trapping is built when PC_ALIGN_CHECK_EN is defined.
module pc_fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
  parameter int unsigned       COUNT_W  = 32
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [ADDR_W-1:0]   NextPC,
  input  logic                PCWrite,
  output logic [ADDR_W-1:0]   CurrentPC,
  output logic                IMemReq,
  output logic [ADDR_W-1:0]   IMemAddr,
  input  logic                IMemAck,
  input  logic [INSTR_W-1:0]  IMemData,
  output logic                InstrValid,
  input  logic                InstrReady,
  output logic [INSTR_W-1:0]  Instruction,
  output logic [ADDR_W-1:0]   InstrPC,
  output logic [COUNT_W-1:0]  FetchCount,
  output logic                AlignFault
);

  fetch_state_e        state_q, state_d;
  logic [INSTR_W-1:0]  instr_q;
  logic [ADDR_W-1:0]   instr_pc_q;
  logic [COUNT_W-1:0]  count_q;

  logic hs_c, pc_accept_c, misaligned_c, pc_en_c, fault_set_c, capture_c;

  // A PC commit is only honoured once per fetched instruction: in EXEC, or together with the handshake.
  assign hs_c        = (state_q == HOLD) && InstrReady;
  assign pc_accept_c = PCWrite && (hs_c || (state_q == EXEC));
  assign pc_en_c     = pc_accept_c && !misaligned_c;
  assign fault_set_c = pc_accept_c && misaligned_c;
  assign capture_c   = (state_q == FETCH) && IMemAck;

`ifdef PC_ALIGN_CHECK_EN
  logic fault_q;

  assign misaligned_c = !pc_aligned(NextPC[1:0]);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fault_q <= 1'b0;
    end else if (fault_set_c) begin
      fault_q <= 1'b1;
    end
  end

  assign AlignFault = fault_q;
`else
  assign misaligned_c = 1'b0;
  assign AlignFault   = 1'b0;
`endif

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk_i (CLK),
    .rst_i (Reset),
    .en_i  (pc_en_c),
    .d_i   (NextPC),
    .q_o   (CurrentPC)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: if (IMemAck) state_d = HOLD;
      HOLD: begin
        if (InstrReady) begin
          if (fault_set_c)  state_d = FAULT;
          else if (pc_en_c) state_d = FETCH;
          else              state_d = EXEC;
        end
      end
      EXEC: begin
        if (fault_set_c)  state_d = FAULT;
        else if (pc_en_c) state_d = FETCH;
      end
      FAULT:   state_d = FAULT;
      default: state_d = FETCH;
    endcase
  end

  // Request is masked by Reset so it is low for the whole reset pulse.
  always_comb begin
    IMemReq    = 1'b0;
    InstrValid = 1'b0;
    case (state_q)
      FETCH:   IMemReq    = !Reset;
      HOLD:    InstrValid = 1'b1;
      default: ;
    endcase
  end

  assign IMemAddr = CurrentPC;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      instr_q    <= '0;
      instr_pc_q <= '0;
      count_q    <= '0;
    end else begin
      if (capture_c) begin
        instr_q    <= IMemData;
        instr_pc_q <= CurrentPC;
      end
      if (hs_c && (count_q != '1)) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  assign Instruction = instr_q;
  assign InstrPC     = instr_pc_q;
  assign FetchCount  = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: fetched words are queued on IMemAck and checked at the decode handshake.
module tb_pc_fetch_unit;

  localparam int unsigned COUNT_W = 3;
  localparam logic [63:0] RST_PC  = 64'h0;

  logic               CLK = 1'b0;
  logic               Reset;
  logic [63:0]        NextPC;
  logic               PCWrite;
  logic [63:0]        CurrentPC;
  logic               IMemReq;
  logic [63:0]        IMemAddr;
  logic               IMemAck;
  logic [31:0]        IMemData;
  logic               InstrValid;
  logic               InstrReady;
  logic [31:0]        Instruction;
  logic [63:0]        InstrPC;
  logic [COUNT_W-1:0] FetchCount;
  logic               AlignFault;

  pc_fetch_unit #(
    .RESET_PC (RST_PC),
    .COUNT_W  (COUNT_W)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .NextPC      (NextPC),
    .PCWrite     (PCWrite),
    .CurrentPC   (CurrentPC),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemAck     (IMemAck),
    .IMemData    (IMemData),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .Instruction (Instruction),
    .InstrPC     (InstrPC),
    .FetchCount  (FetchCount),
    .AlignFault  (AlignFault)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } sb_t;

  sb_t                sb_q[$];
  int                 n_checks = 0;
  int                 n_errors = 0;
  logic [63:0]        exp_pc;
  logic [COUNT_W-1:0] exp_count;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One full fetch: ack after ack_dly cycles, handshake after rdy_dly cycles, then PC commit.
  task automatic do_fetch(input logic [31:0] data, input int ack_dly, input int rdy_dly,
                          input logic [63:0] npc, input bit merge);
    sb_t e;
    for (int i = 0; i < ack_dly; i++) begin
      check("fetch_req", 64'(IMemReq), 64'd1);
      check("fetch_addr", IMemAddr, exp_pc);
      check("fetch_valid", 64'(InstrValid), 64'd0);
      PCWrite  = 1'b1;
      NextPC   = {$urandom, $urandom};
      IMemData = $urandom;
      step();
    end
    PCWrite  = 1'b0;
    IMemAck  = 1'b1;
    IMemData = data;
    sb_q.push_back('{instr: data, pc: exp_pc});
    step();
    IMemAck = 1'b0;
    check("ack_to_valid", 64'(InstrValid), 64'd1);
    for (int i = 0; i < rdy_dly; i++) begin
      check("hold_instr", 64'(Instruction), 64'(data));
      check("hold_req", 64'(IMemReq), 64'd0);
      InstrReady = 1'b0;
      PCWrite    = 1'b1;
      NextPC     = {$urandom, $urandom};
      IMemAck    = 1'b1;
      IMemData   = ~data;
      step();
    end
    IMemAck = 1'b0;
    PCWrite = 1'b0;
    check("hs_valid", 64'(InstrValid), 64'd1);
    check("sb_level", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("sb_instr", 64'(Instruction), 64'(e.instr));
      check("sb_pc", InstrPC, e.pc);
    end
    InstrReady = 1'b1;
    PCWrite    = merge;
    NextPC     = npc;
    step();
    InstrReady = 1'b0;
    PCWrite    = 1'b0;
    if (exp_count != '1) exp_count++;
    check("fetch_count", 64'(FetchCount), 64'(exp_count));
    if (!merge) begin
      check("exec_valid", 64'(InstrValid), 64'd0);
      check("exec_req", 64'(IMemReq), 64'd0);
      step();
      check("exec_idle_req", 64'(IMemReq), 64'd0);
      PCWrite = 1'b1;
      NextPC  = npc;
      step();
      PCWrite = 1'b0;
    end
    exp_pc = npc;
    check("commit_req", 64'(IMemReq), 64'd1);
    check("commit_addr", IMemAddr, npc);
    check("commit_pc", CurrentPC, npc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    Reset      = 1'b1;
    NextPC     = '0;
    PCWrite    = 1'b0;
    IMemAck    = 1'b0;
    IMemData   = '0;
    InstrReady = 1'b0;
    exp_pc     = RST_PC;
    exp_count  = '0;
    #3;
    check("rst_req", 64'(IMemReq), 64'd0);
    check("rst_valid", 64'(InstrValid), 64'd0);
    check("rst_pc", CurrentPC, RST_PC);
    check("rst_count", 64'(FetchCount), 64'd0);
    check("rst_fault", 64'(AlignFault), 64'd0);
    check("rst_instr", 64'(Instruction), 64'd0);
    step();
    Reset = 1'b0;
    #1;
    check("release_req", 64'(IMemReq), 64'd1);
    check("release_addr", IMemAddr, 64'd0);

    do_fetch(32'h8B020020, 5, 3, 64'h4, 1'b0);
    do_fetch($urandom, 1, 0, 64'h2468ACD901110200, 1'b1);

`ifdef PC_ALIGN_CHECK_EN
    IMemAck  = 1'b1;
    IMemData = $urandom;
    step();
    IMemAck    = 1'b0;
    InstrReady = 1'b1;
    step();
    InstrReady = 1'b0;
    PCWrite    = 1'b1;
    NextPC     = exp_pc + 64'h2;
    step();
    PCWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("fault_flag", 64'(AlignFault), 64'd1);
      check("fault_pc", CurrentPC, exp_pc);
      check("fault_req", 64'(IMemReq), 64'd0);
      check("fault_valid", 64'(InstrValid), 64'd0);
      PCWrite = 1'b1;
      NextPC  = 64'h100;
      step();
    end
    PCWrite = 1'b0;
    Reset   = 1'b1;
    step();
    Reset = 1'b0;
    #1;
    check("fault_clear", 64'(AlignFault), 64'd0);
    exp_pc    = RST_PC;
    exp_count = '0;
`else
    do_fetch($urandom, 0, 1, 64'h0000_0000_0000_1002, 1'b0);
    check("unchecked_fault", 64'(AlignFault), 64'd0);
`endif

    for (int i = 0; i < 6; i++) begin
      do_fetch($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               {$urandom, $urandom} & ~64'h3, 1'($urandom_range(0, 1)));
    end

    // Reset mid-handshake must clear everything without a clock edge.
    IMemAck  = 1'b1;
    IMemData = 32'hDEADBEEF;
    step();
    IMemAck = 1'b0;
    check("pre_rst_valid", 64'(InstrValid), 64'd1);
    Reset = 1'b1;
    #1;
    check("async_valid", 64'(InstrValid), 64'd0);
    check("async_pc", CurrentPC, RST_PC);
    check("async_count", 64'(FetchCount), 64'd0);
    check("async_instr", 64'(Instruction), 64'd0);
    check("async_ipc", InstrPC, 64'd0);
    check("async_req", 64'(IMemReq), 64'd0);
    step();
    Reset = 1'b0;
    #1;
    check("rerelease_req", 64'(IMemReq), 64'd1);
    exp_pc    = RST_PC;
    exp_count = '0;

    for (int i = 0; i < 9; i++) begin
      do_fetch($urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               exp_pc + 64'h4, 1'($urandom_range(0, 1)));
    end
    check("count_saturated", 64'(FetchCount), 64'(7));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter COUNT_W, default 32, width of FetchCount.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 NextPC  in  64  next-PC value from the next-PC logic stage.
REQ-006 PCWrite  in  1  commit strobe; loads NextPC into CurrentPC.
REQ-007 CurrentPC  out  64  architectural PC; feeds the next-PC logic stage.
REQ-008 IMemReq  out  1  instruction-memory read request.
REQ-009 IMemAddr  out  64  read address, equal to CurrentPC.
REQ-010 IMemAck  in  1  memory returns IMemData this cycle.
REQ-011 IMemData  in  32  instruction word.
REQ-012 InstrValid  out  1  Instruction/InstrPC valid to decode.
REQ-013 InstrReady  in  1  decode accepts instruction.
REQ-014 Instruction  out  32  fetched word; InstrPC out 64, PC it was fetched from.
REQ-015 FetchCount  out  COUNT_W  number of completed decode handshakes.
REQ-016 AlignFault  out  1  sticky misaligned-PC flag.

Function
REQ-017 FSM states: FETCH, HOLD, EXEC, FAULT; the unit SHALL leave reset in FETCH.
REQ-018 FETCH: IMemReq=1, IMemAddr=CurrentPC, both held stable until IMemAck. On IMemAck, the unit SHALL capture IMemData and CurrentPC and go to HOLD.
REQ-019 HOLD: InstrValid=1, with Instruction/InstrPC stable. On InstrValid&&InstrReady the unit SHALL increment FetchCount and go to EXEC. If PCWrite is also asserted that cycle, it SHALL load the PC and go directly to FETCH.
REQ-020 EXEC: InstrValid=0, IMemReq=0. On PCWrite the unit SHALL set CurrentPC<=NextPC and go to FETCH.
REQ-021 PCWrite SHALL be ignored in FETCH and in HOLD without a handshake; at most one PC update per fetched instruction.
REQ-022 Latency: IMemAck in cycle N -> InstrValid=1 in cycle N+1; PCWrite in cycle M -> IMemReq with the new address in cycle M+1.
REQ-023 FetchCount SHALL saturate at all-ones and not wrap.
REQ-024 CurrentPC arithmetic is none: NextPC is loaded verbatim, 64 bits, with no truncation.
REQ-025 IMemAck outside FETCH SHALL be ignored.

Reset
REQ-026 Reset asserted, at any time including mid-fetch or mid-handshake, SHALL immediately set CurrentPC=RESET_PC, state=FETCH, InstrValid=0, Instruction=0, InstrPC=0, FetchCount=0, AlignFault=0.
REQ-027 IMemReq SHALL be 0 while Reset is high and 1 in the first cycle after deassertion.

Configuration
REQ-028 Macro PC_ALIGN_CHECK_EN defined: a PCWrite accepted with NextPC[1:0]!=0 SHALL NOT update CurrentPC, SHALL set AlignFault=1, and SHALL enter FAULT. FAULT has no requests and no valid, and is left only by Reset.
REQ-029 Macro undefined: NextPC is loaded unchecked, AlignFault is tied 0, and the FAULT state is unreachable.

Structure
REQ-030 Shared package arm_fetch_pkg SHALL hold the FSM state typedef and the ADDR_W=64 and INSTR_W=32 constants.
REQ-031 One sub-module, pc_register: a 64-bit register with enable and asynchronous reset to RESET_PC, instantiated for CurrentPC.

Verification
REQ-032 Reset release with RESET_PC=0 -> IMemReq=1, IMemAddr=0 next cycle; IMemAck with IMemData=32'h8B020020 -> InstrValid=1, Instruction=32'h8B020020, InstrPC=0.
REQ-033 Hold IMemAck=0 for 5 cycles -> IMemReq and IMemAddr stable throughout; InstrValid=0.
REQ-034 InstrReady=0 for 3 cycles in HOLD -> Instruction held; then handshake, PCWrite with NextPC=64'h4 -> IMemAddr=4 next cycle, FetchCount=1.
REQ-035 Handshake and PCWrite in the same cycle with NextPC=64'h2468ACD901110200 -> state FETCH, IMemAddr=64'h2468ACD901110200 next cycle.
REQ-036 Reset pulse while in HOLD -> InstrValid=0, CurrentPC=RESET_PC, FetchCount=0 asynchronously.
REQ-037 With PC_ALIGN_CHECK_EN, PCWrite with NextPC=64'h...0002 -> AlignFault=1, CurrentPC unchanged, IMemReq=0 until Reset.
